// File: rtl/img_stream_gen.sv
// img_stream_gen: per_img_* video frame transmitter fed by a pixel source or test pattern
module img_stream_gen #(
   parameter logic [11:0] IMG_HDISP = 12'd640,
   parameter logic [11:0] IMG_VDISP = 12'd480,
   parameter logic [15:0] H_BLANK   = 16'd16,
   parameter logic [15:0] VS_LEAD   = 16'd4,
   parameter logic [15:0] VS_TAIL   = 16'd4,
   parameter logic [15:0] V_BLANK   = 16'd32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       run,
   input  logic [1:0] mode,
   input  logic       src_valid,
   input  logic [7:0] src_data,
   output logic       src_ready,
   output logic       per_img_vsync,
   output logic       per_img_href,
   output logic       per_img_clken,
   output logic [7:0] per_img_gray,
   output logic       busy,
   output logic       frame_done
);
   typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLK, TAIL, VBLK} state_t;
   state_t      state_q, state_d;
   logic [11:0] x_q, x_d, y_q, y_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  mode_q, mode_d;
   logic        beat, last_px, last_ln, vblk_end;
   logic [7:0]  value;
   assign last_px  = x_q == IMG_HDISP - 12'd1;
   assign last_ln  = y_q == IMG_VDISP - 12'd1;
   assign vblk_end = state_q == VBLK && cnt_q == V_BLANK - 16'd1;
   // state, position counters and latched mode
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end
   // next state and counter updates; every state change restarts cnt
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start || run) state_d = LEAD;
         LEAD:    if (cnt_q == VS_LEAD - 16'd1) state_d = LINE;
         LINE:    if (beat && last_px) state_d = last_ln ? TAIL : HBLK;
         HBLK:    if (cnt_q == H_BLANK - 16'd1) state_d = LINE;
         TAIL:    if (cnt_q == VS_TAIL - 16'd1) state_d = VBLK;
         VBLK:    if (vblk_end) state_d = run ? LEAD : IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d  = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      x_d    = (state_d == LEAD) ? 12'd0 : beat ? (last_px ? 12'd0 : x_q + 12'd1) : x_q;
      y_d    = (state_d == LEAD) ? 12'd0 : (state_q == HBLK && state_d == LINE) ? y_q + 12'd1 : y_q;
      mode_d = (state_d == LEAD && state_q != LEAD) ? mode : mode_q;
   end
   // handshake, beat qualification and pixel value selection
   always_comb begin
      src_ready = state_q == LINE && mode_q == 2'd0;
      beat      = state_q == LINE && (mode_q != 2'd0 || (src_valid && src_ready));
      value     = mode_q == 2'd0 ? src_data :
                  mode_q == 2'd1 ? x_q[7:0] :
                  mode_q == 2'd2 ? y_q[7:0] :
                  (x_q[3] ^ y_q[3]) ? 8'hFF : 8'h00;
   end
   // registered video outputs, one cycle behind state and beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         per_img_vsync <= 1'b0;
         per_img_href  <= 1'b0;
         per_img_clken <= 1'b0;
         per_img_gray  <= 8'd0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         per_img_vsync <= state_q inside {LEAD, LINE, HBLK, TAIL};
         per_img_href  <= state_q == LINE;
         per_img_clken <= beat;
         per_img_gray  <= beat ? value : 8'd0;
         busy          <= state_q != IDLE;
         frame_done    <= vblk_end;
      end
   end
endmodule

// File: tb/tb_img_stream_gen.sv
// tb_img_stream_gen: directed bench for img_stream_gen with small frame geometry
module tb_img_stream_gen;
   logic       clk = 1'b0;
   logic       rst_n, start, run, src_valid;
   logic [1:0] mode;
   logic [7:0] src_data;
   logic       src_ready, per_img_vsync, per_img_href, per_img_clken, busy, frame_done;
   logic [7:0] per_img_gray;
   int checks = 0, errors = 0;
   int cap_vs, cap_lines, cap_fd_low, cap_wait;
   bit cap_to;
   int cap_href[8];
   int cap_gaps[8];
   logic [7:0] cap_gray[$];
   bit tog, acc;
   logic [7:0] sdata;

   img_stream_gen #(
      .IMG_HDISP(12'd8), .IMG_VDISP(12'd4), .H_BLANK(16'd3),
      .VS_LEAD(16'd2), .VS_TAIL(16'd2), .V_BLANK(16'd5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .run(run), .mode(mode),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .per_img_vsync(per_img_vsync), .per_img_href(per_img_href),
      .per_img_clken(per_img_clken), .per_img_gray(per_img_gray),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic src_step();
      if (acc) sdata = sdata + 8'd1;
      if (!src_ready) tog = 1'b1;
      src_valid = src_ready & tog;
      src_data  = sdata;
      acc       = src_valid & src_ready;
      if (src_ready) tog = ~tog;
   endtask

   task automatic capture(input bit drive, input int poke_at, input logic ps, input logic pr, input logic [1:0] pm);
      int hrun, lrun;
      bit done;
      hrun = 0; lrun = 0; done = 1'b0;
      cap_vs = 0; cap_lines = 0; cap_fd_low = 0; cap_wait = 0; cap_to = 1'b0;
      cap_gray.delete();
      for (int i = 0; i < 8; i++) begin cap_href[i] = 0; cap_gaps[i] = 0; end
      forever begin
         @(negedge clk);
         if (drive) src_step();
         if (per_img_vsync) break;
         cap_wait++;
         if (cap_wait > 200) begin cap_to = 1'b1; return; end
      end
      for (int i = 0; i < 600 && !done; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (drive) src_step();
         end
         if (cap_vs == poke_at) begin start = ps; run = pr; mode = pm; end
         if (cap_vs == poke_at + 1) start = 1'b0;
         if (per_img_vsync) begin
            cap_vs++;
            if (per_img_href) begin
               if (hrun == 0 && cap_lines > 0 && cap_lines < 9) cap_gaps[cap_lines-1] = lrun;
               hrun++; lrun = 0;
            end else begin
               if (hrun > 0) begin
                  if (cap_lines < 8) cap_href[cap_lines] = hrun;
                  cap_lines++; hrun = 0;
               end
               lrun++;
            end
         end else cap_fd_low++;
         if (per_img_clken) cap_gray.push_back(per_img_gray);
         if (frame_done) done = 1'b1;
      end
      if (!done) cap_to = 1'b1;
   endtask

   task automatic test_reset();
      bit seen;
      rst_n = 1'b0; start = 1'b0; run = 1'b0; mode = 2'd0; src_valid = 1'b0; src_data = 8'd0;
      repeat (3) @(negedge clk);
      checks++; if (per_img_vsync !== 1'b0) begin errors++; $display("FAIL rst_vsync: got %b expected 0", per_img_vsync); end
      checks++; if (per_img_href !== 1'b0) begin errors++; $display("FAIL rst_href: got %b expected 0", per_img_href); end
      checks++; if (per_img_clken !== 1'b0) begin errors++; $display("FAIL rst_clken: got %b expected 0", per_img_clken); end
      checks++; if (per_img_gray !== 8'd0) begin errors++; $display("FAIL rst_gray: got %h expected 00", per_img_gray); end
      checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || src_ready !== 1'b0) begin errors++; $display("FAIL rst_busy_done_ready: got %b%b%b expected 000", busy, frame_done, src_ready); end
      rst_n = 1'b1; mode = 2'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = per_img_href;
      end
      checks++; if (!seen) begin errors++; $display("FAIL mid_line_wait: got no href expected href within 50 cycles"); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if ({per_img_vsync, per_img_href, per_img_clken, busy} !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {per_img_vsync, per_img_href, per_img_clken, busy}); end
      checks++; if (per_img_gray !== 8'd0) begin errors++; $display("FAIL mid_reset_gray: got %h expected 00", per_img_gray); end
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin @(negedge clk); if (per_img_vsync || busy) seen = 1'b1; end
      checks++; if (seen) begin errors++; $display("FAIL idle_after_reset: got activity expected idle"); end
   endtask

   task automatic test_single_frame();
      mode = 2'd1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      capture(1'b0, -1, 1'b0, 1'b0, 2'd1);
      checks++; if (cap_to) begin errors++; $display("FAIL sf_timeout: got timeout expected complete frame"); end
      checks++; if (cap_vs != 45) begin errors++; $display("FAIL sf_vsync_len: got %0d expected 45", cap_vs); end
      checks++; if (cap_lines != 4) begin errors++; $display("FAIL sf_lines: got %0d expected 4", cap_lines); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (cap_href[i] != 8) begin errors++; $display("FAIL sf_href_len[%0d]: got %0d expected 8", i, cap_href[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         checks++; if (cap_gaps[i] != 3) begin errors++; $display("FAIL sf_gap[%0d]: got %0d expected 3", i, cap_gaps[i]); end
      end
      checks++; if (cap_gray.size() != 32) begin errors++; $display("FAIL sf_beats: got %0d expected 32", cap_gray.size()); end
      for (int i = 0; i < cap_gray.size(); i++) begin
         checks++; if (cap_gray[i] !== 8'(i % 8)) begin errors++; $display("FAIL sf_gray[%0d]: got %h expected %h", i, cap_gray[i], 8'(i % 8)); end
      end
      checks++; if (cap_fd_low != 5) begin errors++; $display("FAIL sf_done_pos: got %0d expected 5", cap_fd_low); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL sf_idle: got busy=%b done=%b expected 0 0", busy, frame_done); end
   endtask

   task automatic test_run_checker();
      mode = 2'd3;
      @(negedge clk); run = 1'b1;
      capture(1'b0, -1, 1'b0, 1'b1, 2'd3);
      run = 1'b0;
      checks++; if (cap_to || cap_vs != 45) begin errors++; $display("FAIL rc_vsync_len: got %0d expected 45", cap_vs); end
      checks++; if (cap_fd_low != 5) begin errors++; $display("FAIL rc_vsync_low: got %0d expected 5", cap_fd_low); end
      checks++; if (cap_gray.size() != 32) begin errors++; $display("FAIL rc_beats: got %0d expected 32", cap_gray.size()); end
      foreach (cap_gray[i]) begin
         checks++; if (cap_gray[i] !== 8'h00) begin errors++; $display("FAIL rc_gray[%0d]: got %h expected 00", i, cap_gray[i]); end
      end
      capture(1'b0, -1, 1'b0, 1'b0, 2'd3);
      checks++; if (cap_wait != 0) begin errors++; $display("FAIL rc_period: got %0d extra low cycles expected 0", cap_wait); end
      checks++; if (cap_to || cap_vs != 45) begin errors++; $display("FAIL rc_vsync_len2: got %0d expected 45", cap_vs); end
   endtask

   task automatic test_source_stall();
      mode = 2'd0; tog = 1'b1; acc = 1'b0; sdata = 8'd0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      capture(1'b1, -1, 1'b0, 1'b0, 2'd0);
      src_valid = 1'b0;
      checks++; if (cap_to || cap_vs != 73) begin errors++; $display("FAIL ss_vsync_len: got %0d expected 73", cap_vs); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (cap_href[i] != 15) begin errors++; $display("FAIL ss_href_len[%0d]: got %0d expected 15", i, cap_href[i]); end
      end
      checks++; if (cap_gray.size() != 32) begin errors++; $display("FAIL ss_beats: got %0d expected 32", cap_gray.size()); end
      foreach (cap_gray[i]) begin
         checks++; if (cap_gray[i] !== 8'(i)) begin errors++; $display("FAIL ss_data[%0d]: got %h expected %h", i, cap_gray[i], 8'(i)); end
      end
   endtask

   task automatic test_start_busy_mode();
      bit seen;
      mode = 2'd1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      capture(1'b0, 14, 1'b1, 1'b0, 2'd2);
      checks++; if (cap_to || cap_gray.size() != 32) begin errors++; $display("FAIL sb_beats: got %0d expected 32", cap_gray.size()); end
      foreach (cap_gray[i]) begin
         checks++; if (cap_gray[i] !== 8'(i % 8)) begin errors++; $display("FAIL sb_gray[%0d]: got %h expected %h", i, cap_gray[i], 8'(i % 8)); end
      end
      seen = 1'b0;
      repeat (20) begin @(negedge clk); if (per_img_vsync || busy) seen = 1'b1; end
      checks++; if (seen) begin errors++; $display("FAIL sb_no_extra_frame: got activity expected idle"); end
   endtask

   task automatic test_run_drop();
      bit seen;
      @(negedge clk); run = 1'b1;
      capture(1'b0, 14, 1'b0, 1'b0, 2'd2);
      checks++; if (cap_to || cap_lines != 4) begin errors++; $display("FAIL rd_lines: got %0d expected 4", cap_lines); end
      checks++; if (cap_gray.size() != 32) begin errors++; $display("FAIL rd_beats: got %0d expected 32", cap_gray.size()); end
      foreach (cap_gray[i]) begin
         checks++; if (cap_gray[i] !== 8'(i / 8)) begin errors++; $display("FAIL rd_gray[%0d]: got %h expected %h", i, cap_gray[i], 8'(i / 8)); end
      end
      checks++; if (cap_fd_low != 5) begin errors++; $display("FAIL rd_done_pos: got %0d expected 5", cap_fd_low); end
      seen = 1'b0;
      repeat (20) begin @(negedge clk); if (per_img_vsync || busy || frame_done) seen = 1'b1; end
      checks++; if (seen) begin errors++; $display("FAIL rd_idle: got activity expected idle"); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_run_checker();
      test_source_stall();
      test_start_busy_mode();
      test_run_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
